// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
// Holds the CPU-side state encoding and the slot-owner encoding.
package dmem_arb_pkg;

    localparam int ADDR_W_DEF     = 32;
    localparam int DATA_W_DEF     = 32;
    localparam int RAM_WORDS_DEF  = 512;
    localparam int STARVE_MAX_DEF = 4;
    localparam int STARVE_W       = 3;

    typedef enum logic {
        C_IDLE   = 1'b0,
        C_RDDONE = 1'b1
    } cstate_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_t;

endpackage

// File: rtl/starve_counter.sv
// Saturating wait counter: counts DMA denial cycles and flags when DMA must be
// forced a slot.
module starve_counter #(
    parameter int W   = 3,
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    logic [W-1:0] cnt;

    assign at_max = (cnt == W'(MAX));

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data RAM arbiter between the CPU MEM stage and a DMA master.
// One access per cycle; CPU has priority unless DMA has waited STARVE_MAX cycles.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int RAM_WORDS  = RAM_WORDS_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    localparam int RA_W      = $clog2(RAM_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [RA_W-1:0]   ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int WIDX_W = ADDR_W - 2;

    cstate_t state;
    owner_t  owner;
    logic    at_max;
    logic    cpu_oor, dma_oor;
    logic    cpu_rd_oor, dma_rd_oor;
    logic    unused_addr_bits;

    assign unused_addr_bits = ^{cpu_addr[1:0], dma_addr[1:0]};

    assign cpu_oor = (cpu_addr[ADDR_W-1:2] >= WIDX_W'(RAM_WORDS));
    assign dma_oor = (dma_addr[ADDR_W-1:2] >= WIDX_W'(RAM_WORDS));

    // Slot is gated while reset is held so every output reads 0 in reset.
    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        owner = OWN_NONE;
        if (!reset) begin
            owner = OWN_NONE;
        end else if (state == C_RDDONE) begin
            if (dma_req) owner = OWN_DMA;
        end else if (dma_req && at_max) begin
            owner = OWN_DMA;
        end else if (cpu_req) begin
            owner = OWN_CPU;
        end else if (dma_req) begin
            owner = OWN_DMA;
        end
    end

    always_comb begin
        ram_en    = (owner != OWN_NONE);
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        unique case (owner)
            OWN_CPU: begin
                ram_we    = cpu_we && !cpu_oor;
                ram_addr  = cpu_addr[RA_W+1:2];
                ram_wdata = cpu_wdata;
            end
            OWN_DMA: begin
                ram_we    = dma_we && !dma_oor;
                ram_addr  = dma_addr[RA_W+1:2];
                ram_wdata = dma_wdata;
            end
            default: ;
        endcase
    end

    assign dma_gnt   = (owner == OWN_DMA);
    assign cpu_stall = reset && (state == C_IDLE) && cpu_req
                       && !((owner == OWN_CPU) && cpu_we);
    assign cpu_rdata = (state == C_RDDONE && !cpu_rd_oor) ? ram_rdata : '0;
    assign dma_rdata = (dma_rvalid && !dma_rd_oor) ? ram_rdata : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= C_IDLE;
            cpu_rd_oor <= 1'b0;
            dma_rvalid <= 1'b0;
            dma_rd_oor <= 1'b0;
        end else begin
            unique case (state)
                C_IDLE: begin
                    if (owner == OWN_CPU && !cpu_we) begin
                        state      <= C_RDDONE;
                        cpu_rd_oor <= cpu_oor;
                    end
                end
                C_RDDONE: state <= C_IDLE;
                default:  state <= C_IDLE;
            endcase
            dma_rvalid <= dma_gnt && !dma_we;
            dma_rd_oor <= dma_oor;
        end
    end

    starve_counter #(
        .W   (STARVE_W),
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk    (clk),
        .reset  (reset),
        .inc    (dma_req && !dma_gnt),
        .clr    (dma_gnt || !dma_req),
        .at_max (at_max)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed test-plan steps followed by a randomized run checked against a
// transaction-level model of the arbitration rules and a reference memory image.
module tb_dmem_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NW = 512;
    localparam int SM = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          cpu_stall;
    logic          dma_req, dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_gnt, dma_rvalid;
    logic [DW-1:0] dma_rdata;
    logic          ram_en, ram_we;
    logic [8:0]    ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;

    logic [DW-1:0] ram_mem [NW];
    logic [DW-1:0] ref_mem [NW];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_gnt    (dma_gnt),
        .dma_rvalid (dma_rvalid),
        .dma_rdata  (dma_rdata),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    // Synchronous-read RAM the arbiter drives.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram_mem[ram_addr] <= ram_wdata;
            ram_rdata <= ram_mem[ram_addr];
        end
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    endtask

    task automatic cpu_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic dma_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        dma_req = 1; dma_we = we; dma_addr = a; dma_wdata = d;
    endtask

    initial begin
        int s, j, waited, own, widx;
        bit c_act, c_rd, c_we, d_act, d_pend, d_we, g;
        logic [AW-1:0] c_addr, d_addr;
        logic [DW-1:0] c_wd, c_exp, d_wd, d_exp;
        bit e_stall;
        logic [DW-1:0] e_crd, e_drd;

        for (int i = 0; i < NW; i++) ram_mem[i] = '0;
        idle_inputs();
        reset = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1;

        // Reset state
        settle();
        check("rst_ram_en", ram_en, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", 32'(ram_addr), 0);
        check("rst_ram_wdata", ram_wdata, 0);
        check("rst_cpu_stall", cpu_stall, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_dma_gnt", dma_gnt, 0);
        check("rst_dma_rvalid", dma_rvalid, 0);
        check("rst_dma_rdata", dma_rdata, 0);
        tick();

        // CPU store with zero stall, then a load with one stall cycle
        cpu_op(1, 32'h10, 32'hDEADBEEF);
        settle();
        check("st_ram_we", ram_we, 1);
        check("st_ram_addr", 32'(ram_addr), 4);
        check("st_ram_wdata", ram_wdata, 32'hDEADBEEF);
        check("st_stall", cpu_stall, 0);
        tick();
        cpu_op(0, 32'h10, '0);
        settle();
        check("ld_stall1", cpu_stall, 1);
        check("ld_ram_en", ram_en, 1);
        check("ld_ram_we", ram_we, 0);
        tick();
        settle();
        check("ld_stall2", cpu_stall, 0);
        check("ld_rdata", cpu_rdata, 32'hDEADBEEF);
        tick();
        idle_inputs();

        // DMA alone: 8 writes then 8 reads with one-cycle read latency
        for (int i = 0; i < 8; i++) begin
            dma_op(1, 32'(i * 4), 32'(i + 1));
            settle();
            check("dma_wr_gnt", dma_gnt, 1);
            tick();
        end
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) dma_op(0, 32'(i * 4), '0);
            else       dma_req = 0;
            settle();
            if (i < 8) check("dma_rd_gnt", dma_gnt, 1);
            check("dma_rvalid", dma_rvalid, (i > 0) ? 1 : 0);
            check("dma_rdata", dma_rdata, 32'(i));
            tick();
        end
        idle_inputs();

        // Back-to-back CPU loads against a continuous DMA read stream
        dma_op(0, 32'(7 * 4), '0);
        for (int k = 0; k < 4; k++) begin
            cpu_op(0, 32'(k * 4), '0);
            settle();
            check("bl_stall", cpu_stall, 1);
            check("bl_gnt_a", dma_gnt, 0);
            check("bl_rvalid", dma_rvalid, (k > 0) ? 1 : 0);
            check("bl_drdata", dma_rdata, (k > 0) ? 32'd8 : 32'd0);
            tick();
            settle();
            check("bl_stall_done", cpu_stall, 0);
            check("bl_crdata", cpu_rdata, 32'(k + 1));
            check("bl_gnt_b", dma_gnt, 1);
            tick();
        end
        idle_inputs();
        settle();
        check("bl_last_rvalid", dma_rvalid, 1);
        check("bl_last_drdata", dma_rdata, 32'd8);
        tick();

        // Back-to-back CPU stores: DMA forced every STARVE_MAX+1 cycles
        s = 0; j = 0;
        cpu_op(1, 32'((200 + s) * 4), 32'hB000 + 32'(s));
        dma_op(1, 32'((100 + j) * 4), 32'hA000 + 32'(j));
        for (int c = 1; c <= 2 * (SM + 1); c++) begin
            g = (c % (SM + 1) == 0);
            settle();
            check("bs_gnt", dma_gnt, 32'(g));
            check("bs_stall", cpu_stall, 32'(g));
            check("bs_ram_we", ram_we, 1);
            tick();
            if (g) begin
                j++;
                dma_op(1, 32'((100 + j) * 4), 32'hA000 + 32'(j));
            end else begin
                s++;
                cpu_op(1, 32'((200 + s) * 4), 32'hB000 + 32'(s));
            end
        end
        idle_inputs();
        tick();

        // Out-of-range store is dropped; out-of-range load returns 0
        cpu_op(1, 32'h800, 32'h12345678);
        settle();
        check("oor_st_we", ram_we, 0);
        check("oor_st_stall", cpu_stall, 0);
        tick();
        cpu_op(0, 32'h800, '0);
        settle();
        check("oor_ld_stall", cpu_stall, 1);
        tick();
        settle();
        check("oor_ld_rdata", cpu_rdata, 0);
        tick();
        cpu_op(0, 32'h0, '0);
        tick();
        settle();
        check("oor_word0_intact", cpu_rdata, 32'd1);
        tick();
        idle_inputs();

        // Reset during a CPU load stall cycle, then during a DMA read grant
        cpu_op(0, 32'h10, '0);
        settle();
        check("rr_stall", cpu_stall, 1);
        #1 reset = 0;
        @(posedge clk);
        #1 reset = 1;
        idle_inputs();
        settle();
        check("rr_cpu_rdata", cpu_rdata, 0);
        check("rr_cpu_stall", cpu_stall, 0);
        tick();
        cpu_op(0, 32'h10, '0);
        settle();
        check("rr_idle_stall", cpu_stall, 1);
        tick();
        settle();
        check("rr_reload", cpu_rdata, 32'd5);
        tick();
        idle_inputs();
        dma_op(0, 32'(7 * 4), '0);
        settle();
        check("rd_gnt", dma_gnt, 1);
        #1 reset = 0;
        @(posedge clk);
        #1 reset = 1;
        idle_inputs();
        settle();
        check("rd_rvalid", dma_rvalid, 0);
        check("rd_rdata", dma_rdata, 0);
        tick();

        // Randomized traffic against a transaction-level model
        for (int i = 0; i < NW; i++) ref_mem[i] = ram_mem[i];
        c_act = 0; c_rd = 0; d_act = 0; d_pend = 0; waited = 0;
        c_we = 0; d_we = 0; c_addr = '0; d_addr = '0; c_wd = '0; d_wd = '0;
        c_exp = '0; d_exp = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!c_act && $urandom_range(0, 2) != 0) begin
                c_act = 1; c_we = 1'($urandom_range(0, 1));
                c_addr = 32'($urandom_range(0, NW + 7) * 4 + $urandom_range(0, 3));
                c_wd = $urandom;
            end
            if (!d_act && $urandom_range(0, 1) != 0) begin
                d_act = 1; d_we = 1'($urandom_range(0, 1));
                d_addr = 32'($urandom_range(0, NW + 7) * 4 + $urandom_range(0, 3));
                d_wd = $urandom;
            end
            cpu_req = c_act; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wd;
            dma_req = d_act; dma_we = d_we; dma_addr = d_addr; dma_wdata = d_wd;

            // 0 none, 1 cpu, 2 dma
            if (c_rd)                       own = d_act ? 2 : 0;
            else if (d_act && waited >= SM) own = 2;
            else if (c_act)                 own = 1;
            else if (d_act)                 own = 2;
            else                            own = 0;
            e_stall = c_rd ? 1'b0 : (c_act && !(own == 1 && c_we));
            e_crd   = c_rd ? c_exp : '0;
            e_drd   = d_pend ? d_exp : '0;

            settle();
            check("rnd_gnt", dma_gnt, 32'(own == 2));
            check("rnd_ram_en", ram_en, 32'(own != 0));
            check("rnd_stall", cpu_stall, 32'(e_stall));
            check("rnd_cpu_rdata", cpu_rdata, e_crd);
            check("rnd_rvalid", dma_rvalid, 32'(d_pend));
            check("rnd_dma_rdata", dma_rdata, e_drd);

            if (d_act && own != 2) waited = (waited < SM) ? waited + 1 : SM;
            else                   waited = 0;
            if (c_rd) begin
                c_act = 0; c_rd = 0;
            end else if (own == 1) begin
                widx = int'(c_addr >> 2);
                if (c_we) begin
                    if (widx < NW) ref_mem[widx] = c_wd;
                    c_act = 0;
                end else begin
                    c_exp = (widx < NW) ? ref_mem[widx] : '0;
                    c_rd = 1;
                end
            end
            d_pend = 0;
            if (own == 2) begin
                widx = int'(d_addr >> 2);
                if (d_we) begin
                    if (widx < NW) ref_mem[widx] = d_wd;
                end else begin
                    d_exp = (widx < NW) ? ref_mem[widx] : '0;
                    d_pend = 1;
                end
                d_act = 0;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Single-port data-memory arbiter that shares the CPU's data RAM between the pipeline MEM stage and a DMA/loader master. It sits between the `CPU` MEM stage and a synchronous-read RAM and sequences one access per cycle. It generates the MEM-stage stall and prevents DMA starvation with a saturating wait counter.

## Interface
- `ADDR_W`, 32, byte-address width of both requesters
- `DATA_W`, 32, data word width
- `RAM_WORDS`, 512, RAM depth in words; RAM word-address width `RA_W = clog2(RAM_WORDS)` = 9
- `STARVE_MAX`, 4, consecutive cycles of DMA denial before DMA is forced a slot

Ports:
- `clk` in 1 system clock, rising edge
- `reset` in 1 asynchronous, active-low reset
- `cpu_req` in 1 MEM-stage load/store request; held while `cpu_stall`=1
- `cpu_we` in 1 1 = store, 0 = load
- `cpu_addr` in ADDR_W byte address
- `cpu_wdata` in DATA_W store data
- `cpu_rdata` out DATA_W load data, valid in the cycle `cpu_stall` falls for a load
- `cpu_stall` out 1 freezes IF..MEM while the CPU access is incomplete
- `dma_req` in 1 DMA beat request; addr/we/wdata stable until `dma_gnt`
- `dma_we` in 1 1 = write, 0 = read
- `dma_addr` in ADDR_W byte address
- `dma_wdata` in DATA_W write data
- `dma_gnt` out 1 beat accepted this cycle
- `dma_rvalid` out 1 read data valid, exactly one cycle after a read `dma_gnt`
- `dma_rdata` out DATA_W DMA read data
- `ram_en` out 1 RAM access this cycle
- `ram_we` out 1 RAM write enable
- `ram_addr` out RA_W word address = addr[RA_W+1:2]
- `ram_wdata` out DATA_W RAM write data
- `ram_rdata` in DATA_W RAM read data, registered, valid the cycle after `ram_en`

## Operation
- FSM for the CPU side: `C_IDLE` and `C_RDDONE`. The owner of the current slot is decided combinationally from the state, the requests and `starve_cnt`.
- **Slot owner**
  - In `C_RDDONE` the CPU is already served, so the slot goes to DMA if `dma_req`.
  - Otherwise, if `dma_req` and `starve_cnt == STARVE_MAX`, the slot goes to DMA.
  - Otherwise, if `cpu_req`, the slot goes to the CPU.
  - Otherwise, if `dma_req`, the slot goes to DMA.
  - Otherwise the cycle is idle (`ram_en`=0).
- **CPU write granted:** `ram_en`=`ram_we`=1. `cpu_stall`=0 in the same cycle. State stays `C_IDLE`.
- **CPU read granted:** `ram_en`=1. `cpu_stall`=1. Next state is `C_RDDONE`.
- **In `C_RDDONE`:** `cpu_rdata`=`ram_rdata`, `cpu_stall`=0, and the state returns to `C_IDLE`. The held `cpu_req` is not re-issued.
- **CPU not granted while `cpu_req`=1:** `cpu_stall`=1.
- **DMA granted:** `dma_gnt`=1. For a read, `dma_rvalid`=1 in the next cycle with `dma_rdata`=`ram_rdata`.
- **`starve_cnt`** (3-bit, saturating at STARVE_MAX):
  - +1 each cycle `dma_req` && !`dma_gnt`.
  - Cleared on `dma_gnt`.
  - Cleared when `dma_req`=0.
- **Out-of-range address** (word index ≥ RAM_WORDS):
  - Write: `ram_we` forced to 0.
  - Read: returns 0.
  - Handshake timing is unchanged.
- Low two address bits are ignored; there are no byte enables.

## Timing
- **Reset:** all outputs 0, state `C_IDLE`, `starve_cnt`=0.
- Reset asserted mid-read suppresses the pending `cpu_rdata` and `dma_rvalid`.
- **Latency:**
  - CPU store: 0 extra cycles.
  - CPU load: 1 stall cycle.
  - DMA read: data arrives 1 cycle after grant.
- At most one `ram_en` per cycle. `dma_gnt` and a CPU grant are never active in the same cycle.
- **Simultaneous requests, `starve_cnt` < STARVE_MAX:** CPU wins and DMA waits.
- **Simultaneous requests, `starve_cnt` = STARVE_MAX:** DMA wins and the CPU stalls one extra cycle.
- **Worst case for the CPU:** one forced DMA slot per STARVE_MAX+1 cycles.
- `cpu_rdata` and `dma_rdata` are undefined (held 0) outside their valid cycles.

## Structure
- Package `dmem_arb_pkg` holds:
  - state encodings `C_IDLE`=1'b0 and `C_RDDONE`=1'b1
  - owner encodings `OWN_NONE`, `OWN_CPU`, `OWN_DMA`
  - default widths
- One sub-module, `starve_counter`: saturating counter with `inc`, `clr` and `at_max`. Everything else is inline.

## Test plan
- Reset low for 2 cycles, then release → all outputs 0. CPU store `addr`=0x10, data 0xDEADBEEF → `ram_we`=1 at `ram_addr`=4 with `cpu_stall`=0. A load from 0x10 → `cpu_stall`=1 for 1 cycle, then `cpu_rdata`=0xDEADBEEF.
- DMA alone writes 0x1..0x8 to words 0..7 → 8 consecutive `dma_gnt`. DMA reads back → each `dma_rvalid` one cycle after its gnt, with matching data.
- CPU issues back-to-back loads while DMA requests continuously → the DMA beat is granted in every `C_RDDONE` slot. `cpu_rdata` is never corrupted.
- CPU issues back-to-back stores while DMA requests continuously → `dma_gnt` in cycle STARVE_MAX+1 (5). The CPU stalls exactly that cycle, and `starve_cnt` returns to 0.
- Store to `addr`=0x800 (word 512) → `ram_we`=0. Load from 0x800 → `cpu_rdata`=0 after 1 stall cycle.
- Assert `reset` in the stall cycle of a CPU load → no `cpu_rdata` or `dma_rvalid` pulse, and after release the state is `C_IDLE`.
